vc_output_scheduler: RTL and testbench

- Per-output-port scheduler for the mesh router. It shares one output port's two virtual-channel output slots (even VC, odd VC) between the four input interfaces that can target that port.
- Each cycle it arbitrates only within the VC selected by the router's polarity phase, using an independent round-robin pointer per VC.
- It tracks slot occupancy per VC until the output controller reports the slot drained downstream.
- It issues a registered one-hot grant that the output controller uses to select data and clear the winning input buffer.

---
 rtl/vc_output_scheduler.sv | 82 ++++++++
 tb/tb_vc_output_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vc_output_scheduler.sv
// rtl/vc_output_scheduler.sv - per-output-port two-VC round-robin slot scheduler
module vc_output_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int VC_NUM  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               polarity,
    input  logic [NUM_REQ-1:0] req_even,
    input  logic [NUM_REQ-1:0] req_odd,
    input  logic [VC_NUM-1:0]  drain,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_vc,
    output logic               grant_valid,
    output logic [VC_NUM-1:0]  busy,
    output logic               proto_err
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr [VC_NUM];
    logic [NUM_REQ-1:0] req_sel;
    logic [PTR_W-1:0]   ptr_sel;
    logic [PTR_W-1:0]   idx;
    logic [PTR_W-1:0]   winner;
    logic               found;
    logic               can_grant;
    logic [VC_NUM-1:0]  busy_next;

    assign req_sel = polarity ? req_odd : req_even;
    assign ptr_sel = ptr[polarity];

    // Rotating priority search starting at the pointer of the eligible VC
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr_sel + PTR_W'(i);
            if (!found && req_sel[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign can_grant = !busy[polarity] && found;

    // A grant can only target an idle slot, so drain and grant never collide on one VC
    always_comb begin
        busy_next = busy & ~drain;
        if (can_grant) begin
            busy_next[polarity] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant       <= '0;
            grant_vc    <= 1'b0;
            grant_valid <= 1'b0;
            busy        <= '0;
            proto_err   <= 1'b0;
            for (int v = 0; v < VC_NUM; v++) begin
                ptr[v] <= '0;
            end
        end else begin
            busy      <= busy_next;
            proto_err <= proto_err | (|(drain & ~busy));
            if (can_grant) begin
                grant         <= NUM_REQ'(1) << winner;
                grant_vc      <= polarity;
                grant_valid   <= 1'b1;
                ptr[polarity] <= winner + 1'b1;
            end else begin
                grant       <= '0;
                grant_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vc_output_scheduler.sv
// tb/tb_vc_output_scheduler.sv - self-checking bench for vc_output_scheduler
module tb_vc_output_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       polarity = 1'b0;
    logic [3:0] req_even = '0;
    logic [3:0] req_odd = '0;
    logic [1:0] drain = '0;
    logic [3:0] grant;
    logic       grant_vc;
    logic       grant_valid;
    logic [1:0] busy;
    logic       proto_err;

    int checks = 0;
    int errors = 0;

    int m_ptr [2];
    bit m_busy [2];
    int m_grant;
    bit m_vc;
    bit m_valid;
    bit m_err;

    typedef struct packed {
        logic       p;
        logic [3:0] re;
        logic [3:0] ro;
        logic [1:0] dr;
        logic [3:0] g;
        logic       vc;
        logic       v;
        logic [1:0] b;
        logic       e;
    } vec_t;

    vec_t tbl [20];

    vc_output_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .polarity    (polarity),
        .req_even    (req_even),
        .req_odd     (req_odd),
        .drain       (drain),
        .grant       (grant),
        .grant_vc    (grant_vc),
        .grant_valid (grant_valid),
        .busy        (busy),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int v = 0; v < 2; v++) begin
            m_ptr[v]  = 0;
            m_busy[v] = 1'b0;
        end
        m_grant = 0;
        m_vc    = 1'b0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endfunction

    // Reference: winner is the first requester at or after the VC's pointer, modulo 4
    function automatic void model_edge(bit p, logic [3:0] re, logic [3:0] ro, logic [1:0] dr);
        logic [3:0] r;
        int w;
        r = p ? ro : re;
        w = -1;
        if (!m_busy[p]) begin
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (m_ptr[p] + i) % 4;
                if (w < 0 && r[k]) w = k;
            end
        end
        for (int v = 0; v < 2; v++) begin
            if (dr[v]) begin
                if (m_busy[v]) m_busy[v] = 1'b0;
                else m_err = 1'b1;
            end
        end
        if (w >= 0) begin
            m_grant   = 1 << w;
            m_vc      = p;
            m_valid   = 1'b1;
            m_busy[p] = 1'b1;
            m_ptr[p]  = (w + 1) % 4;
        end else begin
            m_grant = 0;
            m_valid = 1'b0;
        end
    endfunction

    task automatic compare_model();
        check("model_grant", 32'(grant), 32'(m_grant));
        check("model_grant_vc", 32'(grant_vc), 32'(m_vc));
        check("model_grant_valid", 32'(grant_valid), 32'(m_valid));
        check("model_busy", 32'(busy), 32'({m_busy[1], m_busy[0]}));
        check("model_proto_err", 32'(proto_err), 32'(m_err));
    endtask

    task automatic step(input bit p, input logic [3:0] re, input logic [3:0] ro, input logic [1:0] dr);
        @(negedge clk);
        polarity = p;
        req_even = re;
        req_odd  = ro;
        drain    = dr;
        model_edge(p, re, ro, dr);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_grant_vc"}, 32'(grant_vc), 32'd0);
        check({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_proto_err"}, 32'(proto_err), 32'd0);
    endtask

    // Asserts reset between clock edges, checks the immediate clear, then releases
    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        check_cleared("async_reset");
        polarity = 1'b0;
        req_even = '0;
        req_odd  = '0;
        drain    = '0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        tbl[0]  = '{1'b0, 4'hF, 4'h0, 2'b00, 4'b0001, 1'b0, 1'b1, 2'b01, 1'b0};
        tbl[1]  = '{1'b1, 4'hF, 4'h0, 2'b01, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[2]  = '{1'b0, 4'hF, 4'h0, 2'b00, 4'b0010, 1'b0, 1'b1, 2'b01, 1'b0};
        tbl[3]  = '{1'b1, 4'hF, 4'h0, 2'b01, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[4]  = '{1'b0, 4'hF, 4'h0, 2'b00, 4'b0100, 1'b0, 1'b1, 2'b01, 1'b0};
        tbl[5]  = '{1'b1, 4'hF, 4'h0, 2'b01, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[6]  = '{1'b0, 4'hF, 4'h0, 2'b00, 4'b1000, 1'b0, 1'b1, 2'b01, 1'b0};
        tbl[7]  = '{1'b1, 4'hF, 4'h0, 2'b01, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[8]  = '{1'b0, 4'hF, 4'h0, 2'b00, 4'b0001, 1'b0, 1'b1, 2'b01, 1'b0};
        tbl[9]  = '{1'b1, 4'hF, 4'h0, 2'b01, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[10] = '{1'b1, 4'h4, 4'h0, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[11] = '{1'b0, 4'h4, 4'h0, 2'b00, 4'b0100, 1'b0, 1'b1, 2'b01, 1'b0};
        tbl[12] = '{1'b1, 4'h0, 4'h4, 2'b00, 4'b0100, 1'b1, 1'b1, 2'b11, 1'b0};
        tbl[13] = '{1'b0, 4'h0, 4'h8, 2'b01, 4'b0000, 1'b1, 1'b0, 2'b10, 1'b0};
        tbl[14] = '{1'b1, 4'h0, 4'h8, 2'b00, 4'b0000, 1'b1, 1'b0, 2'b10, 1'b0};
        tbl[15] = '{1'b0, 4'h1, 4'h8, 2'b10, 4'b0001, 1'b0, 1'b1, 2'b01, 1'b0};
        tbl[16] = '{1'b1, 4'h0, 4'h8, 2'b00, 4'b1000, 1'b1, 1'b1, 2'b11, 1'b0};
        tbl[17] = '{1'b1, 4'h0, 4'h0, 2'b11, 4'b0000, 1'b1, 1'b0, 2'b00, 1'b0};
        tbl[18] = '{1'b0, 4'h0, 4'h0, 2'b01, 4'b0000, 1'b1, 1'b0, 2'b00, 1'b1};
        tbl[19] = '{1'b1, 4'h0, 4'h0, 2'b00, 4'b0000, 1'b1, 1'b0, 2'b00, 1'b1};

        model_reset();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            polarity = 1'($urandom);
            req_even = 4'($urandom);
            req_odd  = 4'($urandom);
            drain    = 2'($urandom);
            @(posedge clk);
            #1;
            check_cleared("held_reset");
        end
        @(negedge clk);
        polarity = 1'b0;
        req_even = '0;
        req_odd  = '0;
        drain    = '0;
        reset    = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].p, tbl[i].re, tbl[i].ro, tbl[i].dr);
            check($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
            check($sformatf("tbl%0d_grant_vc", i), 32'(grant_vc), 32'(tbl[i].vc));
            check($sformatf("tbl%0d_grant_valid", i), 32'(grant_valid), 32'(tbl[i].v));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].b));
            check($sformatf("tbl%0d_proto_err", i), 32'(proto_err), 32'(tbl[i].e));
        end

        // Odd slot stays blocked until drained
        step(1'b1, 4'h0, 4'b0100, 2'b00);
        check("blk_first_grant", 32'(grant), 32'b0100);
        for (int n = 0; n < 10; n++) begin
            step(1'b1, 4'h0, 4'b1000, 2'b00);
            check("blk_no_valid", 32'(grant_valid), 32'd0);
            check("blk_busy1", 32'(busy[1]), 32'd1);
        end
        step(1'b1, 4'h0, 4'b1000, 2'b10);
        check("blk_drained", 32'(busy[1]), 32'd0);
        check("blk_drain_no_grant", 32'(grant_valid), 32'd0);
        step(1'b1, 4'h0, 4'b1000, 2'b00);
        check("blk_regrant", 32'(grant), 32'b1000);
        check("blk_regrant_vc", 32'(grant_vc), 32'd1);
        step(1'b0, 4'h0, 4'h0, 2'b10);

        // Reset while a grant pulse is in flight and both slots are occupied
        step(1'b0, 4'hF, 4'h0, 2'b00);
        step(1'b1, 4'h0, 4'hF, 2'b00);
        check("inflight_valid", 32'(grant_valid), 32'd1);
        check("inflight_busy", 32'(busy), 32'b11);
        async_reset();
        step(1'b0, 4'hF, 4'h0, 2'b00);
        check("post_reset_even", 32'(grant), 32'b0001);
        step(1'b1, 4'h0, 4'hF, 2'b00);
        check("post_reset_odd", 32'(grant), 32'b0001);
        check("post_reset_odd_vc", 32'(grant_vc), 32'd1);
        check("post_reset_err", 32'(proto_err), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            logic [1:0] dr;
            for (int v = 0; v < 2; v++) begin
                dr[v] = m_busy[v] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
            end
            step(1'($urandom), 4'($urandom), 4'($urandom), dr);
            if (n % 600 == 599) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
